// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    LOAD_USE = 2'd1,
    MULDIV   = 2'd2,
    MEM      = 2'd3
  } stall_cause_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational comparator: does the ID instruction read the register a load in EX is writing?
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_load,
  input  logic [4:0] ex_rd_addr,
  output logic       hit
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_match = id_use_rs2 && (id_rs2_addr == ex_rd_addr);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hit = ex_load && (ex_rd_addr != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority encoder, wait-state FSM and stall counter.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_e    state, state_next;
  logic         md_pend, md_pend_next;
  logic         lu_hit;
  logic         mem_wait;
  logic         run_eval;
  logic         s_if, s_id, s_ex, s_mem;
  logic         f_id, f_ex, f_wb;
  stall_cause_e cause;

  load_use_detect u_load_use_detect (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_load     (ex_load),
    .ex_rd_addr  (ex_rd_addr),
    .hit         (lu_hit)
  );

  assign mem_wait = (mem_req && !mem_ready) || ((state == MEM_WAIT) && !mem_ready);
  // The mem-wait release cycle re-evaluates the held EX instruction as if in RUN,
  // unless a MUL/DIV op is still outstanding underneath it.
  assign run_eval = (state == RUN) || ((state == MEM_WAIT) && !md_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      md_pend      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state   <= state_next;
      md_pend <= md_pend_next;
      if (stall_if) stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

  always_comb begin
    state_next   = RUN;
    md_pend_next = 1'b0;
    s_if         = 1'b0;
    s_id         = 1'b0;
    s_ex         = 1'b0;
    s_mem        = 1'b0;
    f_id         = 1'b0;
    f_ex         = 1'b0;
    f_wb         = 1'b0;
    cause        = NONE;
    if (mem_wait) begin
      {s_if, s_id, s_ex, s_mem, f_wb} = 5'b11111;
      cause        = MEM;
      state_next   = MEM_WAIT;
      md_pend_next = ((state == MD_WAIT) || md_pend) && !md_done;
    end else if ((state == MEM_WAIT) && md_pend) begin
      state_next = md_done ? RUN : MD_WAIT;
    end else if (((state == MD_WAIT) && !md_done) || (run_eval && ex_md_start && !md_done)) begin
      {s_if, s_id, s_ex} = 3'b111;
      cause      = MULDIV;
      state_next = MD_WAIT;
    end else if (run_eval && ex_redirect) begin
      // Wrong-path ID instruction is squashed, so load-use is deliberately not considered.
      f_id = 1'b1;
      f_ex = 1'b1;
    end else if (run_eval && lu_hit) begin
      s_if  = 1'b1;
      s_id  = 1'b1;
      f_ex  = 1'b1;
      cause = LOAD_USE;
    end
  end

  // Outputs are forced quiet for as long as reset is held, independent of inputs.
  assign stall_if    = rst_n && s_if;
  assign stall_id    = rst_n && s_id;
  assign stall_ex    = rst_n && s_ex;
  assign stall_mem   = rst_n && s_mem;
  assign flush_id    = rst_n && f_id;
  assign flush_ex    = rst_n && f_ex;
  assign flush_wb    = rst_n && f_wb;
  assign stall_cause = rst_n ? cause : NONE;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (4-bit counter to exercise wrap).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // Output vector order: stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_RD   = 7'b0000110;
  localparam logic [6:0] O_MD   = 7'b1110000;
  localparam logic [6:0] O_MEM  = 7'b1111001;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       ld;
    logic [4:0] rd;
    logic       redir;
    logic       mds;
    logic       mdd;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct packed {
    logic [6:0]       outs;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_use_rs1, id_use_rs2, ex_load, ex_redirect;
  logic             ex_md_start, md_done, mem_req, mem_ready;
  logic             stall_if, stall_id, stall_ex, stall_mem;
  logic             flush_id, flush_ex, flush_wb;
  logic [1:0]       stall_cause;
  logic [CNT_W-1:0] stall_cycles;

  exp_t             exp_q[$];
  string            name_q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               checks;
  int               errors;
  bit               stim_done;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_load      (ex_load),
    .ex_rd_addr   (ex_rd_addr),
    .ex_redirect  (ex_redirect),
    .ex_md_start  (ex_md_start),
    .md_done      (md_done),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .flush_wb     (flush_wb),
    .stall_cause  (stall_cause),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Argument order: rst, rs1, rs2, use_rs1, use_rs2, load, rd, redirect, md_start, md_done, mem_req, mem_ready
  function automatic in_t vec(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic ld, logic [4:0] rd, logic redir, logic mds, logic mdd,
                              logic mreq, logic mrdy);
    in_t v;
    v = {rst, rs1, rs2, u1, u2, ld, rd, redir, mds, mdd, mreq, mrdy};
    return v;
  endfunction

  task automatic applyStimulus(input string name, input in_t v, input logic [6:0] eo, input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = v.rst;
    id_rs1_addr = v.rs1;
    id_rs2_addr = v.rs2;
    id_use_rs1  = v.u1;
    id_use_rs2  = v.u2;
    ex_load     = v.ld;
    ex_rd_addr  = v.rd;
    ex_redirect = v.redir;
    ex_md_start = v.mds;
    md_done     = v.mdd;
    mem_req     = v.mreq;
    mem_ready   = v.mrdy;
    if (!v.rst) exp_cnt = '0;
    e.outs  = eo;
    e.cause = ec;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(name);
    if (v.rst && eo[6]) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    logic [6:0] got;
    got = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb};
    checks++;
    if (got !== e.outs || stall_cause !== e.cause) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %b cause %0d, expected %b cause %0d",
               name, got, stall_cause, e.outs, e.cause);
    end
    checks++;
    if (stall_cycles !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s stall_cycles: got %0d, expected %0d", name, stall_cycles, e.cnt);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle away from the active edge.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(n, e);
      end
    end
  end

  initial begin
    in_t idle;
    checks    = 0;
    errors    = 0;
    stim_done = 1'b0;
    exp_cnt   = '0;
    rst_n = 1'b0;
    {id_rs1_addr, id_rs2_addr, ex_rd_addr} = '0;
    {id_use_rs1, id_use_rs2, ex_load, ex_redirect, ex_md_start, md_done, mem_req, mem_ready} = '0;
    idle = vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus("reset_idle",   vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE, 2'd0);
    applyStimulus("reset_busy",   vec(0, 5, 5, 1, 1, 1, 5, 0, 1, 0, 1, 0), O_NONE, 2'd0);
    applyStimulus("idle",         idle, O_NONE, 2'd0);

    applyStimulus("lu_rs2",       vec(1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0), O_LU,   2'd1);
    applyStimulus("lu_clear",     idle, O_NONE, 2'd0);
    applyStimulus("lu_x0",        vec(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), O_NONE, 2'd0);
    applyStimulus("lu_rs1_unused",vec(1, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0), O_NONE, 2'd0);
    applyStimulus("lu_rs1",       vec(1, 7, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0), O_LU,   2'd1);
    applyStimulus("lu_noload",    vec(1, 7, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0), O_NONE, 2'd0);

    applyStimulus("redir_over_lu",vec(1, 0, 5, 0, 1, 1, 5, 1, 0, 0, 0, 0), O_RD,   2'd0);
    applyStimulus("redir_gone",   idle, O_NONE, 2'd0);

    applyStimulus("md_1",         vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MD,   2'd2);
    applyStimulus("md_2_redir",   vec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), O_MD,   2'd2);
    applyStimulus("md_3",         vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MD,   2'd2);
    applyStimulus("md_done",      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), O_NONE, 2'd0);
    applyStimulus("md_after_run", idle, O_NONE, 2'd0);
    applyStimulus("md_same_cycle",vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), O_NONE, 2'd0);

    applyStimulus("mem_1",        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_MEM,  2'd3);
    applyStimulus("mem_2_noreq",  vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_MEM,  2'd3);
    applyStimulus("mem_ready",    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_NONE, 2'd0);
    applyStimulus("mem_after",    idle, O_NONE, 2'd0);

    applyStimulus("mdmem_md",     vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MD,   2'd2);
    applyStimulus("mdmem_mem1",   vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), O_MEM,  2'd3);
    applyStimulus("mdmem_mem2",   vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), O_MEM,  2'd3);
    applyStimulus("mdmem_release",vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1), O_NONE, 2'd0);
    applyStimulus("mdmem_resume", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_MD,   2'd2);
    applyStimulus("mdmem_done",   vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_NONE, 2'd0);
    applyStimulus("mdmem_run",    idle, O_NONE, 2'd0);

    applyStimulus("rst_md_enter", vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MD,   2'd2);
    applyStimulus("rst_md_assert",vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_NONE, 2'd0);
    applyStimulus("rst_md_run",   idle, O_NONE, 2'd0);

    for (int i = 0; i < 17; i++)
      applyStimulus("wrap_stall", vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_MD, 2'd2);
    applyStimulus("wrap_done",    vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), O_NONE, 2'd0);
    applyStimulus("wrap_idle",    idle, O_NONE, 2'd0);

    stim_done = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
